// File: rtl/router_event_if.sv
// Snoop bus carrying one router port's input-acceptance and output-emission strobes
// into the per-port statistics event generator.
interface router_event_if #(
  parameter int BW = 3
);
  logic          flit_in_wr;
  logic          flit_in_hdr;
  logic          flit_in_tail;
  logic          flit_in_bypass;
  logic [BW-1:0] flit_in_hops;
  logic          flit_out_wr;
  logic          flit_out_hdr;
  logic          flit_out_tail;

  modport master (
    output flit_in_wr, flit_in_hdr, flit_in_tail, flit_in_bypass, flit_in_hops,
    output flit_out_wr, flit_out_hdr, flit_out_tail
  );

  modport slave (
    input flit_in_wr, flit_in_hdr, flit_in_tail, flit_in_bypass, flit_in_hops,
    input flit_out_wr, flit_out_hdr, flit_out_tail
  );
endinterface

// File: rtl/router_event_gen.sv
// Per-port statistics event source: registered flit/packet/bypass pulses, bypass hop
// count, and head/tail framing tracking with a sticky error flag and saturating counter.
module router_event_gen #(
  parameter int SMART_NUM = 4,
  parameter int BW        = (SMART_NUM < 1) ? 1 : $clog2(SMART_NUM + 1),
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  router_event_if.slave    snoop,
  output logic             flit_wr_i,
  output logic             pck_wr_i,
  output logic             flit_wr_o,
  output logic             pck_wr_o,
  output logic             flit_in_bypassed,
  output logic [BW-1:0]    bypassed_num,
  output logic             in_pck_active,
  output logic             out_pck_active,
  output logic             proto_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} frame_e;

  frame_e           in_st_q, in_st_d, out_st_q, out_st_d;
  logic [BW-1:0]    hop_q, hop_d;
  logic             flit_wr_i_q, flit_wr_i_d, pck_wr_i_q, pck_wr_i_d;
  logic             flit_wr_o_q, flit_wr_o_d, pck_wr_o_q, pck_wr_o_d;
  logic             bypassed_q, bypassed_d;
  logic             proto_err_q, proto_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_in, err_out;

  // A stray head mid-packet still opens a new packet, so only the tail decides the next state.
  function automatic frame_e frame_next(input frame_e st, input logic hdr, input logic tail);
    if (hdr || st == BODY) return tail ? IDLE : BODY;
    return IDLE;
  endfunction

  function automatic logic frame_err(input frame_e st, input logic hdr);
    return hdr ? (st == BODY) : (st == IDLE);
  endfunction

  function automatic logic [BW-1:0] sat_hops(input logic [BW-1:0] h);
    if (SMART_NUM == 0) return '0;
    if (int'(h) > SMART_NUM) return BW'(SMART_NUM);
    return h;
  endfunction

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] cnt, input logic [1:0] inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_W-1){1'b0}}, inc};
    return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  endfunction

  always_comb begin
    in_st_d  = in_st_q;
    out_st_d = out_st_q;
    hop_d    = hop_q;
    err_in   = 1'b0;
    err_out  = 1'b0;
    if (snoop.flit_in_wr) begin
      err_in  = frame_err(in_st_q, snoop.flit_in_hdr);
      in_st_d = frame_next(in_st_q, snoop.flit_in_hdr, snoop.flit_in_tail);
      if (snoop.flit_in_hdr) hop_d = sat_hops(snoop.flit_in_hops);
    end
    if (snoop.flit_out_wr) begin
      err_out  = frame_err(out_st_q, snoop.flit_out_hdr);
      out_st_d = frame_next(out_st_q, snoop.flit_out_hdr, snoop.flit_out_tail);
    end
    flit_wr_i_d = snoop.flit_in_wr;
    pck_wr_i_d  = snoop.flit_in_wr & snoop.flit_in_hdr;
    flit_wr_o_d = snoop.flit_out_wr;
    pck_wr_o_d  = snoop.flit_out_wr & snoop.flit_out_hdr;
    bypassed_d  = (SMART_NUM > 0) & snoop.flit_in_wr & snoop.flit_in_bypass;
    proto_err_d = proto_err_q | err_in | err_out;
    err_cnt_d   = sat_add(err_cnt_q, {1'b0, err_in} + {1'b0, err_out});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_st_q     <= IDLE;
      out_st_q    <= IDLE;
      hop_q       <= '0;
      flit_wr_i_q <= 1'b0;
      pck_wr_i_q  <= 1'b0;
      flit_wr_o_q <= 1'b0;
      pck_wr_o_q  <= 1'b0;
      bypassed_q  <= 1'b0;
      proto_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      in_st_q     <= in_st_d;
      out_st_q    <= out_st_d;
      hop_q       <= hop_d;
      flit_wr_i_q <= flit_wr_i_d;
      pck_wr_i_q  <= pck_wr_i_d;
      flit_wr_o_q <= flit_wr_o_d;
      pck_wr_o_q  <= pck_wr_o_d;
      bypassed_q  <= bypassed_d;
      proto_err_q <= proto_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign flit_wr_i        = flit_wr_i_q;
  assign pck_wr_i         = pck_wr_i_q;
  assign flit_wr_o        = flit_wr_o_q;
  assign pck_wr_o         = pck_wr_o_q;
  assign flit_in_bypassed = bypassed_q;
  assign bypassed_num     = hop_q;
  assign in_pck_active    = (in_st_q == BODY);
  assign out_pck_active   = (out_st_q == BODY);
  assign proto_err        = proto_err_q;
  assign err_cnt          = err_cnt_q;

endmodule

// File: doc/router_event_gen.md
# router_event_gen

Per-port event source for the simulation statistics path: snoops one router port's input-side flit acceptance and output-side flit emission and produces the registered `router_event_t` field pulses (flit/packet in, flit/packet out, SMART bypass, bypass hop count) that the statistics collector counts. One instance sits beside every router port (`NR x MAX_P` instances). It also tracks packet framing on both directions and flags malformed head/tail sequences.

## Interface
Parameters:
- `SMART_NUM`, 4, maximum routers a flit may bypass; 0 disables SMART (bypass inputs ignored).
- `BW`, `$clog2(SMART_NUM+1)` (minimum 1), width of hop-count fields.
- `ERR_W`, 16, width of protocol-error counter.

Ports (all synchronous to `clk`):
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `flit_in_wr` in 1: flit accepted at this input port this cycle.
- `flit_in_hdr` in 1: accepted flit is a head flit.
- `flit_in_tail` in 1: accepted flit is a tail flit (head+tail = single-flit packet).
- `flit_in_bypass` in 1: accepted flit took the SMART bypass path, not the input buffer.
- `flit_in_hops` in BW: routers bypassed so far, valid only with a head flit.
- `flit_out_wr` in 1: flit sent out of this output port this cycle.
- `flit_out_hdr` in 1, `flit_out_tail` in 1: framing of the outgoing flit.
- `flit_wr_i` out 1, `pck_wr_i` out 1, `flit_wr_o` out 1, `pck_wr_o` out 1, `flit_in_bypassed` out 1: event pulses.
- `bypassed_num` out BW: bypass hop count for the current input packet.
- `in_pck_active` out 1, `out_pck_active` out 1: framing FSM in BODY state.
- `proto_err` out 1: sticky framing-error flag.
- `err_cnt` out ERR_W: saturating count of framing errors.

## Operation
- All event outputs are registered from the same-cycle inputs; no combinational input-to-output path.
- `flit_wr_i` = `flit_in_wr`; `flit_wr_o` = `flit_out_wr`.
- `pck_wr_i` = `flit_in_wr & flit_in_hdr`; `pck_wr_o` = `flit_out_wr & flit_out_hdr` (packets counted at head).
- `flit_in_bypassed` = `flit_in_wr & flit_in_bypass`, forced 0 when SMART_NUM=0. A bypassed flit still asserts `flit_wr_i`.
- Hop latch: on accepted head, latch `min(flit_in_hops, SMART_NUM)` (saturate, never wrap); body/tail flits reuse the latched value. `bypassed_num` output = value applying to the flit registered this cycle (head: new value, same cycle). Forced 0 when SMART_NUM=0. Holds between packets.
- Framing FSM, one per direction, states IDLE/BODY, advance only on the direction's write:
  - IDLE, head&tail -> IDLE; head only -> BODY; non-head flit -> error, stay IDLE (flit counted, no packet).
  - BODY, non-head non-tail -> BODY; tail -> IDLE; head -> error, treated as new packet start (packet counted, hop latch reloaded; head&tail -> IDLE, else BODY).
- Each error sets `proto_err` and increments `err_cnt` by 1, saturating at all-ones. Input and output errors in the same cycle add 2 (saturating).
- `in_pck_active`/`out_pck_active` reflect FSM state after the update.

## Timing
- Latency: inputs at edge N -> outputs valid after edge N+1, held one cycle per event (pulses, no stretching).
- Back-to-back flits every cycle fully supported; no stalls, no handshake back to the router.
- Input and output events in the same cycle are independent; both reported same cycle.
- Reset (`reset`=0 at an edge): all outputs 0, both FSMs IDLE, hop latch 0, `err_cnt` 0, `proto_err` 0. Reset mid-packet discards framing state; first flit after reset that is not a head is an error.
- Inputs while `reset`=0 are ignored.

## Test plan
- Reset: hold `reset`=0 two cycles with `flit_in_wr`=1 -> all outputs 0, `err_cnt`=0.
- Single-flit packet: head+tail in, hops=1 -> next cycle `flit_wr_i`=1, `pck_wr_i`=1, `bypassed_num`=1, `in_pck_active`=0; one-cycle pulse only.
- 4-flit packet, head hops=2, flits on consecutive cycles, flit 2 bypassed; same packet out 3 cycles later -> 4 `flit_wr_i`, 1 `pck_wr_i`, `bypassed_num`=2 on all 4, `flit_in_bypassed` only on flit 2; 4 `flit_wr_o`, 1 `pck_wr_o`; `err_cnt`=0.
- Saturation: SMART_NUM=4, head hops=7 -> `bypassed_num`=4; SMART_NUM=0 build, `flit_in_bypass`=1 -> `flit_in_bypassed`=0, `bypassed_num`=0.
- Framing errors: body flit while IDLE -> `proto_err`=1, `err_cnt`=1, `pck_wr_i`=0; then head, head -> `err_cnt`=2, two `pck_wr_i`; simultaneous in+out errors -> +2; force `err_cnt` near max -> sticks at 0xFFFF.
- Reset mid-packet: head accepted, `reset` pulsed, then tail -> `err_cnt`=1, FSM IDLE, `proto_err`=1.
